// File: rtl/l0_seq.sv
// rtl/l0_seq.sv - layer-0 sequencer: buffers a binary image and serialises KxK windows to the conv datapath
module l0_seq #(
    parameter int IMG_W = 28,
    parameter int K     = 3,
    parameter int NPOOL = 169
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pix_vld,
    input  logic pix,
    input  logic bsy_out,
    input  logic pool_ack,
    output logic strt,
    output logic din,
    output logic tx_done,
    output logic busy,
    output logic ovf_err
);

    localparam int OUT_W = IMG_W - K + 1;
    localparam int NPIX  = IMG_W * IMG_W;
    localparam int AW    = $clog2(NPIX);
    localparam int RW    = $clog2(OUT_W);
    localparam int KW    = $clog2(K * K);
    localparam int CW    = $clog2(NPOOL + 1);
    localparam int unsigned KU = K;
    localparam int unsigned WU = IMG_W;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ISSUE, S_FEED, S_WAIT, S_DRAIN, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [NPIX-1:0] img_q;
    logic [AW-1:0]   ld_ptr_q, ld_ptr_d, wr_addr, rd_addr;
    logic [RW-1:0]   r_q, r_d, c_q, c_d;
    logic [KW-1:0]   k_q, k_d;
    logic [CW-1:0]   ack_q, ack_d;
    logic            first_q;
    logic            strt_q, din_q, tx_done_q, ovf_q;
    logic            din_d, wr_en;

    always_comb begin
        state_d  = state_q;
        ld_ptr_d = ld_ptr_q;
        r_d      = r_q;
        c_d      = c_q;
        k_d      = k_q;
        ack_d    = ack_q;
        wr_en    = 1'b0;
        wr_addr  = ld_ptr_q;
        if (state_q != S_IDLE && pool_ack && ack_q != CW'(NPOOL)) begin
            ack_d = ack_q + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (pix_vld) begin
                    wr_en    = 1'b1;
                    wr_addr  = '0;
                    ld_ptr_d = AW'(1);
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (pix_vld) begin
                    wr_en    = 1'b1;
                    ld_ptr_d = ld_ptr_q + 1'b1;
                    if (ld_ptr_q == AW'(NPIX - 1)) begin
                        r_d     = '0;
                        c_d     = '0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                k_d     = '0;
                state_d = S_FEED;
            end
            S_FEED: begin
                if (k_q == KW'(K * K - 1)) begin
                    state_d = S_WAIT;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_WAIT: begin
                // first_q blocks exit in the first WAIT cycle so the datapath can raise bsy_out
                if (!first_q && !bsy_out) begin
                    if (r_q == RW'(OUT_W - 1) && c_q == RW'(OUT_W - 1)) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_ISSUE;
                        if (c_q == RW'(OUT_W - 1)) begin
                            c_d = '0;
                            r_d = r_q + 1'b1;
                        end else begin
                            c_d = c_q + 1'b1;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (ack_q == CW'(NPOOL)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                ld_ptr_d = '0;
                r_d      = '0;
                c_d      = '0;
                k_d      = '0;
                ack_d    = '0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // din is registered, so the window bit is looked up with the next-cycle k
        rd_addr = AW'((32'(r_q) + 32'(k_d) / KU) * WU + 32'(c_q) + 32'(k_d) % KU);
        din_d   = (state_d == S_FEED) ? img_q[rd_addr] : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ld_ptr_q  <= '0;
            r_q       <= '0;
            c_q       <= '0;
            k_q       <= '0;
            ack_q     <= '0;
            first_q   <= 1'b0;
            strt_q    <= 1'b0;
            din_q     <= 1'b0;
            tx_done_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ld_ptr_q  <= ld_ptr_d;
            r_q       <= r_d;
            c_q       <= c_d;
            k_q       <= k_d;
            ack_q     <= ack_d;
            first_q   <= (state_q == S_FEED);
            strt_q    <= (state_d == S_ISSUE);
            din_q     <= din_d;
            tx_done_q <= (state_d == S_DONE);
            if (pix_vld && state_q != S_IDLE && state_q != S_LOAD) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            img_q[wr_addr] <= pix;
        end
    end

    assign strt    = strt_q;
    assign din     = din_q;
    assign tx_done = tx_done_q;
    assign busy    = (state_q != S_IDLE);
    assign ovf_err = ovf_q;

endmodule

// File: tb/tb_l0_seq.sv
// tb/tb_l0_seq.sv - scoreboard bench for l0_seq with an image/window reference model
module tb_l0_seq;

    localparam int IMG_W = 28;
    localparam int K     = 3;
    localparam int NPOOL = 169;
    localparam int OUT_W = IMG_W - K + 1;

    logic clk = 1'b0;
    logic rst_n, pix_vld, pix, bsy_out, pool_ack;
    logic strt, din, tx_done, busy, ovf_err;

    l0_seq #(.IMG_W(IMG_W), .K(K), .NPOOL(NPOOL)) dut (
        .clk(clk), .rst_n(rst_n), .pix_vld(pix_vld), .pix(pix),
        .bsy_out(bsy_out), .pool_ack(pool_ack), .strt(strt), .din(din),
        .tx_done(tx_done), .busy(busy), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit img_m[IMG_W][IMG_W];
    logic [8:0] exp_q[$];
    int exp_tx[$];
    int n_strt_img = 0, n_tx = 0, last_strt_cyc = 0;
    int ack_left = 0, ack_gap = 0, acks_sent = 0, last_ack_cyc = 0;
    bit ack_any = 0;
    int bcnt = 0, bleft = 0, extra_win = -1;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Conv datapath stand-in: busy for 10 cycles after each start, longer for one chosen window
    initial begin
        bsy_out = 1'b0;
        forever begin
            @(negedge clk);
            if (bleft > 0) begin
                bsy_out = 1'b1;
                bleft--;
            end else begin
                bsy_out = 1'b0;
            end
            if (strt && rst_n) begin
                bleft = (bcnt == extra_win) ? 60 : 10;
                bcnt++;
            end
        end
    end

    // Pooled-output consumer: randomly spaced acknowledgements
    initial begin
        pool_ack = 1'b0;
        forever begin
            @(negedge clk);
            pool_ack = 1'b0;
            if (ack_left > 0 && rst_n && (busy || ack_any)) begin
                if (ack_gap == 0) begin
                    pool_ack = 1'b1;
                    ack_left--;
                    acks_sent++;
                    last_ack_cyc = cyc;
                    ack_gap = $urandom_range(10, 30);
                end else begin
                    ack_gap--;
                end
            end
        end
    end

    // Monitor: captures each window from din and checks it against the scoreboard
    initial begin
        bit capturing = 0, chk_after_tx = 0;
        int fidx = 0, lat;
        logic [8:0] cap, exp_w;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                capturing = 0;
                chk_after_tx = 0;
                n_strt_img = 0;
                continue;
            end
            if (chk_after_tx) begin
                check("busy_after_tx", int'(busy), 0);
                check("tx_single_pulse", int'(tx_done), 0);
                chk_after_tx = 0;
            end
            if (strt) begin
                check("strt_while_bsy", int'(bsy_out), 0);
                check("din_in_issue", int'(din), 0);
                check("strt_overlaps_window", int'(capturing), 0);
                if (n_strt_img > 0) check("strt_spacing_ge11", int'(cyc - last_strt_cyc >= 11), 1);
                last_strt_cyc = cyc;
                n_strt_img++;
                capturing = 1;
                fidx = 0;
            end else if (capturing) begin
                if (fidx < K * K) begin
                    cap[fidx] = din;
                    fidx++;
                    if (fidx == K * K) begin
                        check("window_queue_nonempty", int'(exp_q.size() > 0), 1);
                        if (exp_q.size() > 0) begin
                            exp_w = exp_q.pop_front();
                            check("window_din", int'(cap), int'(exp_w));
                        end
                    end
                end else begin
                    check("din_in_wait", int'(din), 0);
                    capturing = 0;
                end
            end
            if (tx_done) begin
                check("tx_expected", int'(exp_tx.size() > 0), 1);
                if (exp_tx.size() > 0) begin
                    lat = exp_tx.pop_front();
                    check("strts_per_image", n_strt_img, OUT_W * OUT_W);
                    check("acks_before_tx", int'(acks_sent >= NPOOL), 1);
                    check("tx_after_last_ack", int'(cyc > last_ack_cyc), 1);
                    check("windows_left", exp_q.size(), 0);
                    if (lat >= 0) check("tx_latency", cyc - last_strt_cyc, lat);
                end
                n_strt_img = 0;
                n_tx++;
                chk_after_tx = 1;
            end
        end
    end

    task automatic load_image(int mode, int lat);
        logic [8:0] w;
        for (int y = 0; y < IMG_W; y++)
            for (int x = 0; x < IMG_W; x++)
                img_m[y][x] = (mode == 0) ? 1'b1 : (mode == 1) ? bit'((y + x) & 1) : bit'($urandom_range(0, 1));
        for (int r = 0; r < OUT_W; r++)
            for (int c = 0; c < OUT_W; c++) begin
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++)
                        w[i * K + j] = img_m[r + i][c + j];
                exp_q.push_back(w);
            end
        exp_tx.push_back(lat);
        bcnt = 0;
        for (int p = 0; p < IMG_W * IMG_W; p++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                pix_vld = 1'b0;
                @(negedge clk);
            end
            pix_vld = 1'b1;
            pix = img_m[p / IMG_W][p % IMG_W];
        end
        @(negedge clk);
        pix_vld = 1'b0;
    endtask

    task automatic wait_strts(int n);
        int budget = 12000;
        while (n_strt_img < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("strt_wait_in_budget", int'(budget > 0), 1);
    endtask

    task automatic wait_tx();
        int start = n_tx;
        int budget = 12000;
        while (n_tx == start && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("tx_wait_in_budget", int'(budget > 0), 1);
        ack_left = 0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        rst_n = 1'b0;
        pix_vld = 1'b0;
        pix = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_strt", int'(strt), 0);
        check("rst_din", int'(din), 0);
        check("rst_tx_done", int'(tx_done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ovf_err", int'(ovf_err), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // all-ones image, acks finished early
        acks_sent = 0;
        ack_left = NPOOL;
        load_image(0, 13);
        wait_tx();

        // acks in IDLE must be ignored
        ack_any = 1;
        ack_left = 5;
        budget = 400;
        while (ack_left > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("idle_acks_sent", ack_left, 0);
        ack_any = 0;
        repeat (2) @(negedge clk);

        // checkerboard, one long-busy window, final ack in the cycle after the last WAIT
        acks_sent = 0;
        ack_left = NPOOL - 1;
        extra_win = 5;
        load_image(1, -1);
        wait_strts(OUT_W * OUT_W);
        repeat (11) @(negedge clk);
        @(posedge clk);
        ack_gap = 0;
        ack_left = 1;
        wait_tx();
        extra_win = -1;
        check("ovf_clear_before_overrun", int'(ovf_err), 0);

        // random image, pixel overrun during FEED, ack count saturates
        acks_sent = 0;
        ack_left = 200;
        load_image(2, 13);
        wait_strts(3);
        repeat (3) @(negedge clk);
        pix_vld = 1'b1;
        pix = 1'($urandom_range(0, 1));
        @(negedge clk);
        pix_vld = 1'b0;
        @(posedge clk);
        #1;
        check("ovf_set", int'(ovf_err), 1);
        wait_tx();
        check("ovf_sticky", int'(ovf_err), 1);

        // reset during WAIT of window 300 abandons the image
        acks_sent = 0;
        ack_left = 0;
        load_image(2, -1);
        wait_strts(300);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_strt", int'(strt), 0);
        check("midrst_din", int'(din), 0);
        check("midrst_tx_done", int'(tx_done), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_ovf_err", int'(ovf_err), 0);
        exp_q.delete();
        exp_tx.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_after_midrst", int'(busy), 0);

        // fresh image restarts from window r=c=0
        acks_sent = 0;
        ack_left = NPOOL;
        load_image(2, 13);
        wait_tx();
        check("ovf_after_clean_image", int'(ovf_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
